// File: rtl/servo_qd_pkg.sv
// Shared quadrature definitions for servo_quad_speed: state encoding,
// default widths and the forward/reverse transition lookup.
package servo_qd_pkg;

    localparam int unsigned SPD_W_DEF = 18;
    localparam int unsigned POS_W_DEF = 16;

    // Encoding is the raw filtered {A,B} pair.
    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_10 = 2'b10,
        QS_11 = 2'b11,
        QS_01 = 2'b01
    } qd_state_e;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILL
    } qd_step_e;

    function automatic qd_state_e qd_fwd_next(input qd_state_e s);
        case (s)
            QS_00:   return QS_10;
            QS_10:   return QS_11;
            QS_11:   return QS_01;
            default: return QS_00;
        endcase
    endfunction

    function automatic qd_step_e qd_lookup(input qd_state_e prev, input qd_state_e cur);
        if (cur == prev) return STEP_NONE;
        if (cur == qd_fwd_next(prev)) return STEP_FWD;
        if (prev == qd_fwd_next(cur)) return STEP_REV;
        return STEP_ILL;
    endfunction

endpackage

// File: rtl/servo_quad_speed_glitch_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one encoder channel.
module qd_glitch_filter
    import servo_qd_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       lvl_q, lvl_d;
    logic [3:0] run_q, run_d;

    // Once the run reaches FILT_LEN the level flips on the following edge,
    // so a pulse of exactly FILT_LEN samples is still accepted.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        run_d   = run_q;
        if (run_q == 4'(FILT_LEN)) begin
            lvl_d = ~lvl_q;
            run_d = '0;
        end else if (sync2_q != lvl_q) begin
            run_d = run_q + 4'd1;
        end else begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            run_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            run_q   <= run_d;
        end
    end

    assign dout = lvl_q;

endmodule

// File: rtl/servo_quad_speed.sv
// Quadrature decoder and sa-period speed measurement with stall timeout.
// Define QD_X4_PERIOD_EN to time every legal transition instead of sa rises.
module servo_quad_speed
    import servo_qd_pkg::*;
#(
    parameter int unsigned SPD_W    = SPD_W_DEF,
    parameter int unsigned POS_W    = POS_W_DEF,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TIMEOUT  = 50000
) (
    input  logic                    qdmclk,
    input  logic                    qdrstn,
    input  logic                    sa,
    input  logic                    sb,
    output logic [SPD_W-1:0]        speed,
    output logic                    spddav,
    output logic                    dir,
    output logic signed [POS_W-1:0] pos,
    output logic                    stall,
    output logic                    err
);

    localparam logic [SPD_W-1:0] CNT_MAX = '1;
    localparam logic [SPD_W-1:0] TO_M1   = SPD_W'(TIMEOUT - 1);
    localparam logic [SPD_W-1:0] TO_VAL  = SPD_W'(TIMEOUT);

    logic       a_filt, b_filt;
    logic [1:0] cur_ab, prev_ab;
    qd_step_e   step;
    logic       qual;

    qd_state_e        prev_q, prev_d;
    logic [SPD_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [SPD_W-1:0] speed_q, speed_d;
    logic             spddav_q, spddav_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             stall_q, stall_d;
    logic             err_q, err_d;

    qd_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (qdmclk),
        .rstn (qdrstn),
        .din  (sa),
        .dout (a_filt)
    );

    qd_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (qdmclk),
        .rstn (qdrstn),
        .din  (sb),
        .dout (b_filt)
    );

    always_comb begin
        cur_ab  = {a_filt, b_filt};
        prev_ab = prev_q;
        step    = qd_lookup(prev_q, qd_state_e'(cur_ab));
`ifdef QD_X4_PERIOD_EN
        qual    = (step == STEP_FWD) || (step == STEP_REV);
`else
        qual    = !prev_ab[1] && cur_ab[1] && (step != STEP_ILL);
`endif

        prev_d   = qd_state_e'(cur_ab);
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + SPD_W'(1);
        armed_d  = armed_q;
        speed_d  = speed_q;
        spddav_d = 1'b0;
        dir_d    = dir_q;
        pos_d    = pos_q;
        stall_d  = stall_q;
        err_d    = err_q;

        case (step)
            STEP_FWD: begin
                pos_d = pos_q + POS_W'(1);
                dir_d = 1'b1;
            end
            STEP_REV: begin
                pos_d = pos_q - POS_W'(1);
                dir_d = 1'b0;
            end
            STEP_ILL: err_d = 1'b1;
            default: ;
        endcase

        // An edge arriving on the timeout cycle takes priority over the stall.
        if (qual) begin
            if (armed_q) begin
                speed_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + SPD_W'(1);
                spddav_d = 1'b1;
            end
            cnt_d   = '0;
            armed_d = 1'b1;
            stall_d = 1'b0;
        end else if (cnt_q == TO_M1) begin
            stall_d  = 1'b1;
            speed_d  = TO_VAL;
            spddav_d = 1'b1;
            armed_d  = 1'b0;
        end
    end

    always_ff @(posedge qdmclk) begin
        if (!qdrstn) begin
            prev_q   <= QS_00;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            speed_q  <= '0;
            spddav_q <= 1'b0;
            dir_q    <= 1'b1;
            pos_q    <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            speed_q  <= speed_d;
            spddav_q <= spddav_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    assign speed  = speed_q;
    assign spddav = spddav_q;
    assign dir    = dir_q;
    assign pos    = pos_q;
    assign stall  = stall_q;
    assign err    = err_q;

endmodule

// File: tb/tb_servo_quad_speed.sv
// Directed/randomised bench for servo_quad_speed against a transition-level model.
module tb_servo_quad_speed;

    localparam int unsigned SPD_W    = 18;
    localparam int unsigned POS_W    = 16;
    localparam int unsigned FILT_LEN = 4;
    localparam int unsigned TIMEOUT  = 50000;
    // Input driven at a negedge becomes visible at the outputs LAT edges later.
    localparam int unsigned LAT      = FILT_LEN + 4;

    logic             qdmclk = 1'b0;
    logic             qdrstn = 1'b0;
    logic             sa = 1'b0;
    logic             sb = 1'b0;
    logic [SPD_W-1:0] speed;
    logic             spddav, dir, stall, err;
    logic [POS_W-1:0] pos;

    servo_quad_speed #(
        .SPD_W    (SPD_W),
        .POS_W    (POS_W),
        .FILT_LEN (FILT_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .qdmclk (qdmclk),
        .qdrstn (qdrstn),
        .sa     (sa),
        .sb     (sb),
        .speed  (speed),
        .spddav (spddav),
        .dir    (dir),
        .pos    (pos),
        .stall  (stall),
        .err    (err)
    );

    always #5 qdmclk = ~qdmclk;

    int unsigned cyc = 0;
    always @(posedge qdmclk) cyc <= cyc + 1;

    longint unsigned obs_q[$];
    longint unsigned exp_q[$];

    always @(posedge qdmclk) begin
        #2;
        if (spddav === 1'b1) obs_q.push_back({32'(speed), cyc});
    end

    int checks = 0;
    int errors = 0;

    logic [POS_W-1:0] m_pos;
    bit               m_dir, m_err, m_armed, m_stall, m_last_valid;
    int unsigned      m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Gray-code position within one electrical cycle: 00,10,11,01.
    function automatic int unsigned gidx(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gab(input int unsigned i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_pos = '0; m_dir = 1'b1; m_err = 1'b0;
        m_armed = 1'b0; m_stall = 1'b0; m_last_valid = 1'b0; m_last = 0;
    endtask

    // Stall fires TIMEOUT cycles after the last qualifying edge unless an edge intervenes.
    task automatic model_advance(input int unsigned t);
        if (m_last_valid && !m_stall && t >= m_last + LAT + TIMEOUT) begin
            exp_q.push_back({32'(TIMEOUT), m_last + LAT + TIMEOUT});
            m_stall = 1'b1;
            m_armed = 1'b0;
        end
    endtask

    task automatic drive_ab(input logic na, input logic nb, input int unsigned hold);
        int unsigned d, stp;
        bit q;
        @(negedge qdmclk);
        d   = cyc;
        stp = (gidx(na, nb) + 4 - gidx(sa, sb)) % 4;
        if (stp == 2) m_err = 1'b1;
        else if (stp == 1) begin m_pos = m_pos + 1'b1; m_dir = 1'b1; end
        else if (stp == 3) begin m_pos = m_pos - 1'b1; m_dir = 1'b0; end
`ifdef QD_X4_PERIOD_EN
        q = (stp == 1) || (stp == 3);
`else
        q = (stp != 2) && !sa && na;
`endif
        if (q) begin
            model_advance(d + LAT - 1);
            if (m_armed) exp_q.push_back({32'(d - m_last), d + LAT});
            m_last = d; m_last_valid = 1'b1; m_armed = 1'b1; m_stall = 1'b0;
        end
        sa = na;
        sb = nb;
        repeat (hold - 1) @(negedge qdmclk);
    endtask

    task automatic quad(input bit fwd, input int unsigned hold);
        int unsigned i;
        logic [1:0] ab;
        i  = gidx(sa, sb);
        ab = gab(fwd ? i + 1 : i + 3);
        drive_ab(ab[1], ab[0], hold);
    endtask

    task automatic glitch(input logic na, input logic nb, input int unsigned len);
        logic oa, ob;
        @(negedge qdmclk);
        oa = sa; ob = sb;
        sa = na; sb = nb;
        repeat (len) @(negedge qdmclk);
        sa = oa; sb = ob;
    endtask

    task automatic checkpoint(input string tag);
        int unsigned n;
        model_advance(cyc);
        chk({tag, ".pos"},   64'(pos),   64'(m_pos));
        chk({tag, ".dir"},   64'(dir),   64'(m_dir));
        chk({tag, ".err"},   64'(err),   64'(m_err));
        chk({tag, ".stall"}, 64'(stall), 64'(m_stall));
        chk({tag, ".nev"},   64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) chk({tag, ".event"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input int unsigned n, input bit check);
        @(negedge qdmclk);
        qdrstn = 1'b0;
        sa = 1'b0;
        sb = 1'b0;
        repeat (n) @(negedge qdmclk);
        if (check) begin
            chk("rst.speed",  64'(speed),  64'd0);
            chk("rst.spddav", 64'(spddav), 64'd0);
            chk("rst.dir",    64'(dir),    64'd1);
            chk("rst.pos",    64'(pos),    64'd0);
            chk("rst.stall",  64'(stall),  64'd0);
            chk("rst.err",    64'(err),    64'd0);
        end
        qdrstn = 1'b1;
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned w;
        int unsigned target;
        model_reset();
        do_reset(3, 1'b1);

        // Forward at A period 1000.
        for (int i = 0; i < 8; i++) begin
            quad(1'b1, 250);
            checkpoint("fwd");
            if (i == 3) chk("fwd.pos4", 64'(pos), 64'd4);
        end
`ifndef QD_X4_PERIOD_EN
        chk("fwd.speed", 64'(speed), 64'd1000);
`endif
        chk("fwd.pos8", 64'(pos), 64'd8);

        for (int i = 0; i < 16; i++) begin
            quad(1'($urandom_range(0, 1)), $urandom_range(20, 400));
            checkpoint("rand");
        end

        // Reverse from zero wraps below zero.
        do_reset(3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            quad(1'b0, 250);
            checkpoint("rev");
        end
        chk("rev.pos", 64'(pos), 64'hFFF8);
        chk("rev.dir", 64'(dir), 64'd0);
        chk("rev.err", 64'(err), 64'd0);
`ifndef QD_X4_PERIOD_EN
        chk("rev.speed", 64'(speed), 64'd1000);
`endif

        glitch(1'b1, 1'b0, FILT_LEN - 1);
        repeat (20) @(negedge qdmclk);
        checkpoint("glitch_short");
        chk("glitch_short.pos", 64'(pos), 64'hFFF8);

        drive_ab(1'b1, 1'b0, FILT_LEN);
        drive_ab(1'b0, 1'b0, 30);
        checkpoint("pulse_min");

        drive_ab(1'b1, 1'b1, 30);
        checkpoint("illegal");
        chk("illegal.err", 64'(err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            quad(1'b1, 40);
            checkpoint("after_ill");
        end

        // Stall timeout after the motor stops.
        do_reset(3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            quad(1'b1, 250);
            checkpoint("pre_stall");
        end
        w = 0;
        while (spddav !== 1'b1 && w < TIMEOUT + 2000) begin
            @(negedge qdmclk);
            w++;
        end
        chk("stall.strobe", 64'(spddav), 64'd1);
        chk("stall.flag",   64'(stall),  64'd1);
        chk("stall.speed",  64'(speed),  64'(TIMEOUT));
        checkpoint("stall");
        @(negedge qdmclk);
        chk("stall.one_cycle", 64'(spddav), 64'd0);
        for (int i = 0; i < 5; i++) begin
            quad(1'b1, 250);
            checkpoint("post_stall");
        end
`ifndef QD_X4_PERIOD_EN
        chk("post_stall.speed", 64'(speed), 64'd1000);
`endif

        // Reset while the period counter sits at 600.
        target = m_last + LAT + 600;
        while (cyc + 1 < target) @(negedge qdmclk);
        do_reset(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            quad(1'b1, 250);
            checkpoint("post_rst");
        end
`ifndef QD_X4_PERIOD_EN
        chk("post_rst.speed", 64'(speed), 64'd1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_quad_speed.md
Name: servo_quad_speed

Overview:
- Motor-side quadrature feedback front end that drives the servo speed loop's measured-speed input.
- Synchronises and glitch-filters encoder channels sa/sb, then decodes quadrature to give direction and a wrapping position count.
- Measures the period between successive sa rising edges in qdmclk cycles and presents it as speed with a one-cycle spddav strobe.
- Stall timeout reports a saturated speed when the motor stops.

Parameters:
- SPD_W, 18: width of speed and the period counter.
- POS_W, 16: width of the position counter.
- FILT_LEN, 4: consecutive identical synchronised samples needed to accept a level change (range 1..15).
- TIMEOUT, 50000: cycles without a qualifying edge before stall (must be < 2^SPD_W).

Ports:
- qdmclk, in, 1: single clock (1 MHz in system).
- qdrstn, in, 1: reset. Synchronous, active-low.
- sa, in, 1: encoder channel A, asynchronous.
- sb, in, 1: encoder channel B, asynchronous.
- speed, out, SPD_W: last measured period in qdmclk cycles.
- spddav, out, 1: one-cycle strobe; speed is new this cycle.
- dir, out, 1: 1 = forward (A leads B), 0 = reverse.
- pos, out, POS_W: signed position count, wraps.
- stall, out, 1: no qualifying edge for TIMEOUT cycles.
- err, out, 1: sticky illegal-transition flag.

Behaviour:
- Reset (qdrstn=0 at a qdmclk edge):
  - speed=0, spddav=0, dir=1, pos=0, stall=0, err=0.
  - Sync flops, filters, period counter and previous state all cleared to 0.
  - armed=0.
  - Reset mid-measurement discards the partial period.
- Synchroniser: 2 flops per channel.
- Filter, per channel:
  - Run counter runs while the synchronised sample differs from the filtered level; it clears when they agree.
  - Filtered level toggles when the counter reaches FILT_LEN.
  - Pulses shorter than FILT_LEN cycles are never seen.
- Latency: input transition captured at edge k → filtered change at k+2+FILT_LEN → outputs (pos, dir, speed, spddav) update at k+3+FILT_LEN.
- Decode: compares filtered {A,B} with the previous registered {A,B}.
  - Forward sequence is 00→10→11→01→00; pos+1 and dir=1.
  - Reverse sequence; pos−1 and dir=0.
  - pos wraps modulo 2^POS_W.
  - Both bits changing is illegal: err=1 (held until reset); pos and dir unchanged; no speed event.
- Period counter cnt:
  - Increments every cycle, saturating at 2^SPD_W−1.
  - Qualifying edge (filtered A 0→1, legal transition):
    - armed=1: speed=cnt+1 (saturating), spddav=1.
    - armed=0: no spddav.
    - In both cases cnt=0, armed=1, stall=0.
- Stall: when cnt == TIMEOUT−1 and there is no edge this cycle:
  - stall=1, speed=TIMEOUT, spddav=1 (once), armed=0.
  - cnt keeps counting, saturating.
  - The next qualifying edge clears stall, restarts cnt and produces no spddav.
- Simultaneous edge and timeout: the edge wins, and stall is not set.
- spddav is high exactly one cycle per event. The consumer's edge detect and !spddav re-arm are satisfied.

Optional Feature:
- Macro: QD_X4_PERIOD_EN.
- Defined: every legal quadrature transition (either channel, either direction) is a qualifying edge. speed is the inter-count period at 4× resolution.
- Undefined: only the filtered sa rising edge qualifies, as above.
- pos, dir and err behave identically in both builds.

Decomposition:
- Package servo_qd_pkg holds:
  - state encoding constants QS_00/QS_10/QS_11/QS_01;
  - default widths SPD_W_DEF = 18 and POS_W_DEF = 16;
  - the forward/reverse lookup function.
- Sub-module qd_glitch_filter (synchroniser + run-length filter, parameter FILT_LEN) is instantiated once per channel.

Test Plan:
- Reset, then a forward cycle with 250-cycle quarter-phases (A period 1000):
  - first A rise gives no spddav;
  - second rise gives spddav with speed=1000 and dir=1;
  - pos increments by 4 per cycle.
- Reverse sequence, 8 transitions from pos=0 → pos=0xFFF8, dir=0, err=0, speed=1000.
- 3-cycle glitch on sa (FILT_LEN=4) → no change on pos, spddav or err. A 4-cycle pulse is accepted.
- sa and sb toggled in the same cycle (held ≥ FILT_LEN) → err=1 and stays 1; pos unchanged; no spddav.
- Stop after edges:
  - at cnt=TIMEOUT−1 → stall=1, spddav one cycle, speed=50000;
  - next A rise → stall=0, no spddav;
  - following rise 1000 cycles later → speed=1000.
- qdrstn low mid-period (cnt=600) → all outputs return to reset values the next cycle; the first post-reset A rise gives no spddav.
